// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

   localparam int DATA_W_DEF       = 8;
   localparam int WORD_BYTES_DEF   = 4;
   localparam int FLUSH_CYCLES_DEF = 16;
   localparam int WORD_CNT_W       = 16;

   // FILL collects bytes from the FIFO, HOLD presents a word downstream.
   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } rd_state_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO pop side and the packed-word valid/ready side.
// Latency: n/a (wiring only).
// Backpressure: word_ready from the consumer; fifo_empty from the FIFO.
// master: the packer (drives fifo_get and the word_* outputs).
// slave : the environment (FIFO plus downstream consumer).
interface fifo_rd_packer_if
   import fifo_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int WORD_BYTES = WORD_BYTES_DEF
);
   localparam int BC_W = $clog2(WORD_BYTES) + 1;

   logic                         fifo_empty;
   logic [DATA_W-1:0]            fifo_data;
   logic                         fifo_get;
   logic [DATA_W*WORD_BYTES-1:0] word_out;
   logic [BC_W-1:0]              word_bytes;
   logic                         word_valid;
   logic                         word_ready;
   logic [WORD_CNT_W-1:0]        word_cnt;

   modport master (
      input  fifo_empty, fifo_data, word_ready,
      output fifo_get, word_out, word_bytes, word_valid, word_cnt
   );

   modport slave (
      output fifo_empty, fifo_data, word_ready,
      input  fifo_get, word_out, word_bytes, word_valid, word_cnt
   );
endinterface

// File: rtl/fifo_rd_packer_lane_reg.sv
// One byte lane of the packed word: load on write enable, zero on clear.
// Latency: 1 cycle from i_we to o_q.
// Backpressure: none; the caller gates i_we.
// Ports: i_clk, i_rst (sync, active high), i_clr (sync clear), i_we, i_d, o_q.
module fifo_rd_lane_reg #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);
   logic [DATA_W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_q <= '0;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the dual-clock byte FIFO (rclk side) and packs WORD_BYTES of them into a little-endian word.
// Latency: WORD_BYTES+2 cycles minimum per word (pop, 1-cycle FIFO read latency, capture, valid, handshake).
// Backpressure: while word_valid is held waiting for word_ready no pops are issued; fifo_get never fires on empty.
// Ports: rclk, reset (sync, active high), bus (fifo_rd_packer_if.master: fifo_empty/fifo_data/fifo_get,
//        word_out/word_bytes/word_valid/word_ready, word_cnt).
// Optional: define FIFO_RD_PACKER_FLUSH_EN to flush a partial word after FLUSH_CYCLES idle cycles.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int WORD_BYTES   = WORD_BYTES_DEF,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input logic             rclk,
   input logic             reset,
   fifo_rd_packer_if.master bus
);
   localparam int BC_W   = $clog2(WORD_BYTES) + 1;
   localparam int WORD_W = DATA_W * WORD_BYTES;

   localparam logic [BC_W:0]   LVL_FULL = (BC_W+1)'(WORD_BYTES);
   localparam logic [BC_W-1:0] BC_FULL  = BC_W'(WORD_BYTES);
   localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WORD_BYTES - 1);

   rd_state_t             r_state;
   logic [BC_W-1:0]       r_byte_cnt;
   logic                  r_pend;
   logic                  r_word_valid;
   logic [BC_W-1:0]       r_word_bytes;
   logic [WORD_CNT_W-1:0] r_word_cnt;

   logic                  w_get;
   logic                  w_capture;
   logic                  w_hshake;
   logic                  w_full_next;
   logic                  w_flush;
   logic [BC_W:0]         w_fill_lvl;
   logic [WORD_BYTES-1:0] w_lane_we;
   logic [WORD_W-1:0]     w_word;

   // Bytes already captured plus the one still in flight must leave room for another pop.
   assign w_fill_lvl  = {1'b0, r_byte_cnt} + {{BC_W{1'b0}}, r_pend};
   assign w_get       = (r_state == FILL) && !bus.fifo_empty && (w_fill_lvl < LVL_FULL) && !reset;
   assign w_capture   = r_pend;
   assign w_hshake    = r_word_valid && bus.word_ready;
   assign w_full_next = w_capture && (r_byte_cnt == LAST_IDX);

   for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
      assign w_lane_we[g] = w_capture && (r_byte_cnt == BC_W'(g));

      fifo_rd_lane_reg #(
         .DATA_W (DATA_W)
      ) u_lane (
         .i_clk (rclk),
         .i_rst (reset),
         .i_clr (w_hshake),
         .i_we  (w_lane_we[g]),
         .i_d   (bus.fifo_data),
         .o_q   (w_word[g*DATA_W +: DATA_W])
      );
   end

`ifdef FIFO_RD_PACKER_FLUSH_EN
   localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);

   logic [IDLE_W-1:0] r_idle;
   logic              w_idle;

   // Idle means a partial word is parked with nothing in flight and nothing being popped.
   assign w_idle  = (r_state == FILL) && (r_byte_cnt != '0) && !r_pend && !w_get;
   assign w_flush = w_idle && (r_idle == IDLE_W'(FLUSH_CYCLES - 1));

   always_ff @(posedge rclk) begin
      if (reset) begin
         r_idle <= '0;
      end else if (w_capture || w_hshake || w_flush) begin
         r_idle <= '0;
      end else if (w_idle) begin
         r_idle <= r_idle + IDLE_W'(1);
      end
   end
`else
   // Without the idle counter a partial word waits for more bytes indefinitely.
   assign w_flush = (FLUSH_CYCLES < 0);
`endif

   always_ff @(posedge rclk) begin
      if (reset) begin
         r_state      <= FILL;
         r_byte_cnt   <= '0;
         r_pend       <= 1'b0;
         r_word_valid <= 1'b0;
         r_word_bytes <= '0;
         r_word_cnt   <= '0;
      end else begin
         r_pend <= w_get;
         if (w_capture) begin
            r_byte_cnt <= r_byte_cnt + BC_W'(1);
         end
         case (r_state)
            FILL: begin
               if (w_full_next || w_flush) begin
                  r_state      <= HOLD;
                  r_word_valid <= 1'b1;
                  r_word_bytes <= w_full_next ? BC_FULL : r_byte_cnt;
               end
            end
            HOLD: begin
               if (w_hshake) begin
                  r_state      <= FILL;
                  r_word_valid <= 1'b0;
                  r_word_bytes <= '0;
                  r_byte_cnt   <= '0;
                  r_word_cnt   <= r_word_cnt + WORD_CNT_W'(1);
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign bus.fifo_get   = w_get;
   assign bus.word_out   = w_word;
   assign bus.word_bytes = r_word_bytes;
   assign bus.word_valid = r_word_valid;
   assign bus.word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural 1-cycle-latency byte FIFO.
// Latency: n/a.
// Backpressure: word_ready driven per test.
module tb_fifo_rd_packer;
   import fifo_pkg::*;

   localparam int DW = 8;
   localparam int WB = 4;

   logic rclk  = 1'b0;
   logic reset = 1'b1;
   always #5 rclk = ~rclk;

   fifo_rd_packer_if #(.DATA_W(DW), .WORD_BYTES(WB)) bus ();

   fifo_rd_packer #(
      .DATA_W       (DW),
      .WORD_BYTES   (WB),
      .FLUSH_CYCLES (16)
   ) dut (
      .rclk  (rclk),
      .reset (reset),
      .bus   (bus.master)
   );

   int total = 0;
   int bad   = 0;

   // FIFO model: pops at the edge where fifo_get is high, data appears the next cycle.
   logic [7:0] mem [0:511];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       gate   = 1'b0;

   assign bus.fifo_empty = (rd_ptr == wr_ptr) || gate;

   always @(posedge rclk) begin
      if (reset) begin
         rd_ptr <= wr_ptr;
      end else if (bus.fifo_get) begin
         bus.fifo_data <= mem[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   // Monitor: accepted words and protocol counters, sampled mid-cycle.
   logic [31:0] got_w [$];
   logic [2:0]  got_b [$];
   int n_get = 0, n_valid = 0, n_hold_get = 0, n_empty_get = 0, run = 0, max_run = 0;

   always @(negedge rclk) begin
      if (bus.word_valid && bus.word_ready) begin
         got_w.push_back(bus.word_out);
         got_b.push_back(bus.word_bytes);
      end
      if (bus.fifo_get) begin
         n_get++;
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (bus.word_valid) n_valid++;
      if (bus.word_valid && bus.fifo_get) n_hold_get++;
      if (bus.fifo_get && bus.fifo_empty) n_empty_get++;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge rclk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic reset_dut();
      reset          = 1'b1;
      gate           = 1'b0;
      bus.word_ready = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_words(input int target, input int budget, input string tag);
      int c = 0;
      while (got_w.size() < target && c < budget) begin
         tick();
         c++;
      end
      if (got_w.size() < target) check({tag, "_timeout"}, got_w.size(), target);
   endtask

   function automatic logic [31:0] word_at(input int i);
      if (i < got_w.size()) return got_w[i];
      return 32'hDEADBEEF;
   endfunction

   function automatic logic [2:0] bytes_at(input int i);
      if (i < got_b.size()) return got_b[i];
      return 3'h7;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, g0, v0, mism;
      logic [7:0]  exp_b [$];
      logic [31:0] ew;

      // Reset state.
      bus.word_ready = 1'b0;
      reset          = 1'b1;
      tick(3);
      @(negedge rclk);
      check("rst_get",   bus.fifo_get,   0);
      check("rst_valid", bus.word_valid, 0);
      check("rst_word",  bus.word_out,   0);
      check("rst_bytes", bus.word_bytes, 0);
      check("rst_cnt",   bus.word_cnt,   0);
      tick();
      reset = 1'b0;

      // Basic pack.
      base = got_w.size(); g0 = n_get; v0 = n_valid;
      push(8'hFF); push(8'h00); push(8'hAA); push(8'h55);
      bus.word_ready = 1'b1;
      wait_words(base + 1, 20, "basic");
      @(negedge rclk);
      check("basic_word",  word_at(base),  32'h55AA00FF);
      check("basic_bytes", bytes_at(base), 4);
      check("basic_gets",  n_get - g0,     4);
      check("basic_burst", max_run,        4);
      check("basic_vcyc",  n_valid - v0,   1);
      check("basic_cnt",   bus.word_cnt,   1);

      // Backpressure.
      reset_dut();
      base = got_w.size(); g0 = n_get;
      for (int i = 1; i <= 8; i++) push(8'(i));
      tick(10);
      @(negedge rclk);
      check("bp_valid", bus.word_valid, 1);
      check("bp_hold",  bus.word_out,   32'h04030201);
      check("bp_gets",  n_get - g0,     4);
      tick();
      bus.word_ready = 1'b1;
      wait_words(base + 2, 30, "bp");
      @(negedge rclk);
      check("bp_w0",  word_at(base),     32'h04030201);
      check("bp_w1",  word_at(base + 1), 32'h08070605);
      check("bp_cnt", bus.word_cnt,      2);

      // FIFO empty mid-word.
      reset_dut();
      bus.word_ready = 1'b1;
      base = got_w.size(); g0 = n_get;
      push(8'h11); push(8'h22);
      tick(20);
      @(negedge rclk);
      check("gap_gets", n_get - g0, 2);
`ifdef FIFO_RD_PACKER_FLUSH_EN
      wait_words(base + 1, 10, "flush");
      @(negedge rclk);
      check("flush_word",  word_at(base),  32'h00002211);
      check("flush_bytes", bytes_at(base), 2);
      tick();
      push(8'h33); push(8'h44);
      wait_words(base + 2, 40, "flush2");
      @(negedge rclk);
      check("flush2_word",  word_at(base + 1),  32'h00004433);
      check("flush2_bytes", bytes_at(base + 1), 2);
`else
      check("gap_nowords", got_w.size() - base, 0);
      check("gap_valid",   bus.word_valid,      0);
      tick();
      push(8'h33); push(8'h44);
      wait_words(base + 1, 20, "gap");
      @(negedge rclk);
      check("gap_word",  word_at(base),  32'h44332211);
      check("gap_bytes", bytes_at(base), 4);
      check("gap_cnt",   bus.word_cnt,   1);
`endif

      // Reset mid-word: one full word, then two bytes captured, then reset.
      reset_dut();
      bus.word_ready = 1'b1;
      base = got_w.size();
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hB1); push(8'hB2);
      wait_words(base + 1, 20, "pre_rst");
      tick(4);
      @(negedge rclk);
      check("mid_partial", bus.word_out,   32'h0000B2B1);
      check("mid_cnt",     bus.word_cnt,   1);
      check("mid_valid",   bus.word_valid, 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge rclk);
      check("post_rst_word",  bus.word_out,   0);
      check("post_rst_valid", bus.word_valid, 0);
      check("post_rst_bytes", bus.word_bytes, 0);
      check("post_rst_cnt",   bus.word_cnt,   0);
      check("post_rst_get",   bus.fifo_get,   0);
      tick();
      base = got_w.size();
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      wait_words(base + 1, 20, "after_rst");
      @(negedge rclk);
      check("after_rst_word", word_at(base), 32'hA4A3A2A1);
      check("after_rst_cnt",  bus.word_cnt,  1);

      // Counter wrap.
      reset_dut();
      force dut.r_word_cnt = 16'hFFFF;
      tick();
      release dut.r_word_cnt;
      @(negedge rclk);
      check("wrap_pre", bus.word_cnt, 16'hFFFF);
      tick();
      base = got_w.size();
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      bus.word_ready = 1'b1;
      wait_words(base + 1, 20, "wrap");
      @(negedge rclk);
      check("wrap_cnt", bus.word_cnt, 16'h0000);

      // Random empty toggling and ready jitter against a byte scoreboard.
      reset_dut();
      base = got_w.size();
      for (int i = 0; i < 1000; i++) begin
         tick();
         gate           = 1'($urandom_range(0, 1));
         bus.word_ready = ($urandom_range(0, 3) != 0);
         if (exp_b.size() < 200 && $urandom_range(0, 2) == 0) begin
            exp_b.push_back(8'($urandom_range(0, 255)));
            push(exp_b[exp_b.size() - 1]);
         end
      end
      gate           = 1'b0;
      bus.word_ready = 1'b1;
      while (exp_b.size() < 200) begin
         exp_b.push_back(8'($urandom_range(0, 255)));
         push(exp_b[exp_b.size() - 1]);
      end
      wait_words(base + 50, 600, "rnd");
      @(negedge rclk);
      mism = 0;
      for (int w = 0; w < 50; w++) begin
         ew = {exp_b[4*w+3], exp_b[4*w+2], exp_b[4*w+1], exp_b[4*w]};
         if (word_at(base + w) !== ew) mism++;
      end
      check("rnd_count",     got_w.size() - base, 50);
      check("rnd_words",     mism,                0);
      check("rnd_empty_get", n_empty_get,         0);
      check("hold_get",      n_hold_get,          0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer for the dual-clock byte FIFO. It sits in the rclk domain.
- It pops bytes using get/empty/data_out and packs WORD_BYTES consecutive bytes into one little-endian word.
- It presents each word downstream on a valid/ready handshake.
- It is the counterpart of the write-side producer that drives put/data_in.

Parameters:
- DATA_W, 8, FIFO byte width.
- WORD_BYTES, 4, bytes per output word (2..8).
- FLUSH_CYCLES, 16, idle cycles before a partial word is flushed (used only with the optional feature).

Ports:
- rclk  input  1  read-domain clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, in the rclk domain.
- fifo_data  input  DATA_W  FIFO data_out; valid one rclk cycle after fifo_get.
- fifo_get  output  1  FIFO pop request (get).
- word_out  output  DATA_W*WORD_BYTES  packed word; byte 0 is the first popped.
- word_bytes  output  $clog2(WORD_BYTES)+1  count of valid bytes in word_out.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  downstream accepts the word.
- word_cnt  output  16  count of words delivered; wraps at 0xFFFF to 0.

Behaviour:
- Reset values: fifo_get=0, word_valid=0, word_out=0, word_bytes=0, word_cnt=0, byte_cnt=0, pend=0, state=FILL.
- States:
  - FILL: collecting bytes.
  - HOLD: word_valid high, waiting for word_ready.
- fifo_get is combinational:
  - fifo_get = (state==FILL) & !fifo_empty & (byte_cnt + pend < WORD_BYTES) & !reset.
  - Back-to-back pops are allowed, giving one byte per cycle.
  - fifo_get is never asserted while fifo_empty=1.
- pend is a registered copy of fifo_get. FIFO read latency is fixed at 1.
- Capture: when pend=1, fifo_data is written into lane byte_cnt (bits [8*byte_cnt +: 8]) and byte_cnt increments.
- FILL->HOLD occurs on the cycle the captured byte makes byte_cnt==WORD_BYTES.
  - word_valid rises on the next edge.
  - word_bytes=WORD_BYTES.
- In HOLD:
  - word_out and word_bytes are held stable.
  - No pops are issued.
  - word_valid stays high until word_ready=1.
- Handshake cycle (word_valid & word_ready):
  - Next edge: word_valid=0, byte_cnt=0, all lanes cleared to 0, word_cnt+1, state=FILL.
  - Pops may resume in the cycle after the handshake. A full word therefore takes WORD_BYTES+2 cycles minimum.
- word_ready while word_valid=0 is ignored.
- FIFO empty mid-word: byte_cnt holds and the partial word waits indefinitely (feature off).
- Reset mid-operation:
  - All state clears on the next edge.
  - A byte in flight (pend=1) is discarded.
  - The system asserts the same reset to the FIFO, so no stale data survives.

Optional Feature:
- Macro: FIFO_RD_PACKER_FLUSH_EN
- When defined, an idle counter increments each cycle in FILL with byte_cnt>0, pend=0 and fifo_get=0.
  - It resets to 0 on any capture or handshake.
- When the counter reaches FLUSH_CYCLES:
  - Enter HOLD with word_bytes=byte_cnt.
  - Unused upper lanes are 0.
- A partial word then completes the normal handshake.
- When the macro is undefined:
  - No idle counter exists.
  - Only full words are emitted.
  - word_bytes is always WORD_BYTES or 0.

Decomposition:
- Shared package fifo_pkg:
  - DATA_W default.
  - State enum {FILL, HOLD}.
  - WORD_CNT_W=16.
- One natural sub-module, fifo_rd_lane_reg:
  - Per-lane byte register with write enable and clear.
  - Instantiated WORD_BYTES times.
- The FSM, counters and flush logic stay at the top level.

Test Plan:
- Basic pack:
  - Stimulus: FIFO preloaded with FF,00,AA,55; word_ready=1.
  - Response: 4 consecutive fifo_get pulses; word_out=0x55AA00FF, word_bytes=4, word_valid for 1 cycle, word_cnt=1.
- Backpressure:
  - Stimulus: 8 bytes 01..08; word_ready=0 for 10 cycles, then 1.
  - Response: word_out=0x04030201 held stable with no fifo_get during HOLD; then 0x08070605; word_cnt=2.
- Empty mid-word:
  - Stimulus: bytes 11,22 written; 20-cycle gap; then 33,44 written.
  - Response: fifo_get low during the gap; single word 0x44332211.
  - Flush variant: with the feature enabled, 0x00002211 with word_bytes=2 after 16 idle cycles.
- Reset mid-word:
  - Stimulus: after 2 bytes captured, reset for 1 cycle; then bytes A1..A4.
  - Response: all outputs 0 after reset; next word 0xA4A3A2A1, word_cnt=1.
- Counter wrap:
  - Stimulus: force word_cnt=0xFFFF, then one handshake.
  - Response: word_cnt=0x0000.
- Empty protection:
  - Stimulus: random fifo_empty toggling over 1000 cycles.
  - Response: fifo_get & fifo_empty is never 1; no bytes lost or duplicated versus the scoreboard.
